// File: rtl/controlador_posse.sv
// Basketball shot-clock controller: countdown FSM with pause, reload,
// possession change and a tick-timed expiry buzzer.
module controlador_posse #(
  parameter int unsigned TEMPO_POSSE  = 24,
  parameter int unsigned TEMPO_REBOTE = 14,
  parameter int unsigned BUZZER_TICKS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       recarregar_24,
  input  logic       recarregar_14,
  input  logic       trocar_posse,
  output logic [4:0] tempo,
  output logic       buzzer,
  output logic       posse,
  output logic [1:0] estado,
  output logic       rodando
);

  localparam logic [1:0] PARADO   = 2'b00;
  localparam logic [1:0] CONTANDO = 2'b01;
  localparam logic [1:0] PAUSADO  = 2'b10;
  localparam logic [1:0] ESGOTADO = 2'b11;

  localparam logic [4:0] POSSE_T  = 5'(TEMPO_POSSE);
  localparam logic [4:0] REBOTE_T = 5'(TEMPO_REBOTE);
  localparam logic [3:0] BZ_T     = 4'(BUZZER_TICKS);

  logic [1:0] estado_q, estado_d;
  logic [4:0] tempo_q, tempo_d;
  logic       buzzer_q, buzzer_d;
  logic       posse_q, posse_d;
  logic       rodando_q, rodando_d;
  logic [3:0] cnt_q, cnt_d;

  // Events that have no effect in the current state are treated as absent,
  // so they never mask a lower-priority event (e.g. tick in ESGOTADO).
  always_comb begin
    estado_d = estado_q;
    tempo_d  = tempo_q;
    buzzer_d = buzzer_q;
    posse_d  = posse_q;
    cnt_d    = cnt_q;
    if (trocar_posse) begin
      posse_d  = ~posse_q;
      tempo_d  = POSSE_T;
      estado_d = PARADO;
      buzzer_d = 1'b0;
      cnt_d    = '0;
    end else if (recarregar_24 || recarregar_14) begin
      if (recarregar_24) begin
        tempo_d = POSSE_T;
      end else if (tempo_q < REBOTE_T) begin
        tempo_d = REBOTE_T;
      end
      if (estado_q == ESGOTADO) begin
        estado_d = PARADO;
        buzzer_d = 1'b0;
        cnt_d    = '0;
      end
    end else begin
      case (estado_q)
        PARADO: begin
          if (iniciar) estado_d = CONTANDO;
        end
        CONTANDO: begin
          if (pausar) begin
            estado_d = PAUSADO;
          end else if (tick) begin
            if (tempo_q > 5'd1) begin
              tempo_d = tempo_q - 5'd1;
            end else begin
              tempo_d  = '0;
              estado_d = ESGOTADO;
              buzzer_d = 1'b1;
              cnt_d    = '0;
            end
          end
        end
        PAUSADO: begin
          if (iniciar) estado_d = CONTANDO;
        end
        default: begin
          if (tick && buzzer_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == BZ_T) buzzer_d = 1'b0;
          end
        end
      endcase
    end
    rodando_d = (estado_d == CONTANDO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= PARADO;
      tempo_q   <= POSSE_T;
      buzzer_q  <= 1'b0;
      posse_q   <= 1'b0;
      rodando_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      tempo_q   <= tempo_d;
      buzzer_q  <= buzzer_d;
      posse_q   <= posse_d;
      rodando_q <= rodando_d;
      cnt_q     <= cnt_d;
    end
  end

  assign tempo   = tempo_q;
  assign buzzer  = buzzer_q;
  assign posse   = posse_q;
  assign estado  = estado_q;
  assign rodando = rodando_q;

endmodule

// File: tb/tb_controlador_posse.sv
// Scoreboard bench for controlador_posse: expected output vectors are queued
// as each cycle of stimulus is driven and compared against captured outputs.
module tb_controlador_posse;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0, iniciar = 1'b0, pausar = 1'b0;
  logic       recarregar_24 = 1'b0, recarregar_14 = 1'b0, trocar_posse = 1'b0;
  logic [4:0] tempo;
  logic       buzzer, posse, rodando;
  logic [1:0] estado;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Vector layout: {tempo[4:0], buzzer, posse, estado[1:0], rodando}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  controlador_posse #(
    .TEMPO_POSSE (24),
    .TEMPO_REBOTE(14),
    .BUZZER_TICKS(2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tick         (tick),
    .iniciar      (iniciar),
    .pausar       (pausar),
    .recarregar_24(recarregar_24),
    .recarregar_14(recarregar_14),
    .trocar_posse (trocar_posse),
    .tempo        (tempo),
    .buzzer       (buzzer),
    .posse        (posse),
    .estado       (estado),
    .rodando      (rodando)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] mk(input int t, input bit bz, input bit ps,
                                    input int st, input bit rd);
    return {5'(t), bz, ps, 2'(st), rd};
  endfunction

  // One clock cycle with the given input pulses; output snapshot 1ns after the edge.
  task automatic pulse(input bit tk, input bit ini, input bit pau,
                       input bit r24, input bit r14, input bit tp);
    @(negedge clock);
    tick = tk; iniciar = ini; pausar = pau;
    recarregar_24 = r24; recarregar_14 = r14; trocar_posse = tp;
    @(posedge clock);
    #1;
    obs_q.push_back({tempo, buzzer, posse, estado, rodando});
    tick = 0; iniciar = 0; pausar = 0;
    recarregar_24 = 0; recarregar_14 = 0; trocar_posse = 0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    reset = 1'b1;
    #12;
    got = {tempo, buzzer, posse, estado, rodando};
    total++;
    if (got !== mk(24, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL reset: got %b want %b", got, mk(24, 0, 0, 0, 0));
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_countdown();
    logic [9:0] e, o;
    exp_q.push_back(mk(24, 0, 0, 0, 0)); pulse(1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(24, 0, 0, 1, 1)); pulse(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 23; i++) begin
      exp_q.push_back(mk(24 - i, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(0, 1, 0, 3, 0)); pulse(1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 1, 0, 3, 0)); pulse(1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 3, 0)); pulse(1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 3, 0)); pulse(0, 1, 0, 0, 0, 0);
    exp_q.push_back(mk(0, 0, 0, 3, 0)); pulse(1, 0, 1, 0, 0, 0);
    exp_q.push_back(mk(14, 0, 0, 0, 0)); pulse(0, 0, 0, 0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL countdown: no output captured, want %b", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL countdown: tempo=%0d bz=%b posse=%b estado=%b rod=%b want tempo=%0d bz=%b posse=%b estado=%b rod=%b",
                   o[9:5], o[4], o[3], o[2:1], o[0], e[9:5], e[4], e[3], e[2:1], e[0]);
        end
      end
    end
  endtask

  task automatic test_pause();
    logic [9:0] e, o;
    exp_q.push_back(mk(14, 0, 0, 1, 1)); pulse(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(14 - i, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(10, 0, 0, 2, 0)); pulse(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(mk(10, 0, 0, 2, 0)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(10, 0, 0, 1, 1)); pulse(0, 1, 0, 0, 0, 0);
    exp_q.push_back(mk(9, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL pause: no output captured, want %b", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL pause: got %b want %b (tempo %0d vs %0d)", o, e, o[9:5], e[9:5]);
        end
      end
    end
  endtask

  task automatic test_rebote();
    logic [9:0] e, o;
    exp_q.push_back(mk(24, 0, 0, 1, 1)); pulse(0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(mk(24 - i, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(20, 0, 0, 1, 1)); pulse(0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 11; i++) begin
      exp_q.push_back(mk(20 - i, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(14, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL rebote: no output captured, want %b", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL rebote: got %b want %b (tempo %0d vs %0d)", o, e, o[9:5], e[9:5]);
        end
      end
    end
  endtask

  task automatic test_troca_buzzer();
    logic [9:0] e, o;
    for (int i = 1; i <= 13; i++) begin
      exp_q.push_back(mk(14 - i, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(0, 1, 0, 3, 0)); pulse(1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(24, 0, 1, 0, 0)); pulse(1, 1, 0, 0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL troca: no output captured, want %b", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL troca: got %b want %b", o, e);
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [9:0] e, o;
    exp_q.push_back(mk(24, 0, 1, 1, 1)); pulse(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) begin
      exp_q.push_back(mk(24 - i, 0, 1, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    exp_q.push_back(mk(24, 0, 1, 1, 1)); pulse(1, 0, 1, 1, 0, 0);
    exp_q.push_back(mk(24, 0, 0, 0, 0)); pulse(1, 1, 0, 0, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL priority: no output captured, want %b", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL priority: got %b want %b (tempo %0d vs %0d)", o, e, o[9:5], e[9:5]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] e, o, got;
    exp_q.push_back(mk(24, 0, 1, 0, 0)); pulse(0, 0, 0, 0, 0, 1);
    exp_q.push_back(mk(24, 0, 1, 1, 1)); pulse(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      exp_q.push_back(mk(24 - i, 0, 1, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    end
    #2;
    reset = 1'b1;
    #1;
    got = {tempo, buzzer, posse, estado, rodando};
    total++;
    if (got !== mk(24, 0, 0, 0, 0)) begin
      bad++;
      $display("FAIL async_reset: got %b want %b", got, mk(24, 0, 0, 0, 0));
    end
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(mk(24, 0, 0, 0, 0)); pulse(1, 0, 0, 0, 0, 0);
    exp_q.push_back(mk(24, 0, 0, 1, 1)); pulse(0, 1, 0, 0, 0, 0);
    exp_q.push_back(mk(23, 0, 0, 1, 1)); pulse(1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL async_seq: no output captured, want %b", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          bad++;
          $display("FAIL async_seq: got %b want %b (tempo %0d vs %0d)", o, e, o[9:5], e[9:5]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_rebote();
    test_troca_buzzer();
    test_priority();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/controlador_posse.md
CONTROLADOR_POSSE -- requirements
Module: controlador_posse

Interface
REQ-001 SHALL have parameter TEMPO_POSSE, default 24, full shot-clock reload value in seconds (1..31).
REQ-002 SHALL have parameter TEMPO_REBOTE, default 14, offensive-rebound reload value in seconds (1..TEMPO_POSSE).
REQ-003 SHALL have parameter BUZZER_TICKS, default 2, number of tick pulses the buzzer stays on after expiry (1..15).
REQ-004 clock  input  1  single system clock (50 MHz board clock); all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 tick  input  1  one-cycle enable pulse at 1 Hz, synchronous to clock.
REQ-007 iniciar  input  1  one-cycle pulse, start/resume countdown (debounced upstream).
REQ-008 pausar  input  1  one-cycle pulse, pause countdown.
REQ-009 recarregar_24  input  1  one-cycle pulse, reload TEMPO_POSSE.
REQ-010 recarregar_14  input  1  one-cycle pulse, conditional reload TEMPO_REBOTE.
REQ-011 trocar_posse  input  1  one-cycle pulse, possession change.
REQ-012 tempo  output  5  remaining seconds, unsigned binary (feeds bin-to-BCD converter).
REQ-013 buzzer  output  1  expiry horn, active-high.
REQ-014 posse  output  1  team in possession, 0 = team A, 1 = team B (drives display-select mux).
REQ-015 estado  output  2  FSM state code.
REQ-016 rodando  output  1  high only in CONTANDO.

Function
REQ-017 SHALL implement FSM states PARADO=00, CONTANDO=01, PAUSADO=10, ESGOTADO=11; all outputs registered, updated the cycle after the causing input.
REQ-018 PARADO: iniciar -> CONTANDO; tick ignored.
REQ-019 CONTANDO: tick with tempo>1 -> tempo-1; tick with tempo==1 -> tempo=0, ESGOTADO, buzzer=1; pausar -> PAUSADO.
REQ-020 PAUSADO: iniciar -> CONTANDO; tick ignored; tempo frozen.
REQ-021 ESGOTADO: tempo held at 0, never wraps; iniciar, pausar ignored; buzzer SHALL drop after BUZZER_TICKS ticks counted from the cycle after entry; state held until a reload or trocar_posse.
REQ-022 recarregar_24: tempo=TEMPO_POSSE in any state; state kept in PARADO/CONTANDO/PAUSADO; ESGOTADO -> PARADO.
REQ-023 recarregar_14: if tempo<TEMPO_REBOTE, tempo=TEMPO_REBOTE, else tempo unchanged; state rules as REQ-022 (ESGOTADO -> PARADO always).
REQ-024 trocar_posse: posse toggles, tempo=TEMPO_POSSE, state -> PARADO from any state.
REQ-025 Leaving ESGOTADO by any event SHALL clear buzzer and the buzzer tick counter in the same update.
REQ-026 Simultaneous-event priority, highest first: trocar_posse, recarregar_24, recarregar_14, pausar, iniciar, tick; lower-priority events in that cycle are discarded entirely (a reload coinciding with tick produces no decrement).
REQ-027 Held (multi-cycle) input levels SHALL be treated as repeated pulses; no edge detection inside this block.
REQ-028 tempo SHALL never exceed TEMPO_POSSE nor go below 0.

Reset
REQ-029 On reset assertion, immediately and independent of clock: estado=PARADO, tempo=TEMPO_POSSE, buzzer=0, posse=0, rodando=0, buzzer counter=0.
REQ-030 Reset mid-countdown or mid-buzzer SHALL abort without residual state; first active edge after deassertion obeys REQ-018.

Verification
REQ-031 Reset, iniciar, 24 ticks -> tempo 23..1 then 0, estado=11 and buzzer=1 on the cycle after tick 24; buzzer=0 after 2 further ticks.
REQ-032 Count to tempo=10, pausar, 5 ticks, iniciar, 1 tick -> tempo stays 10 while paused, then 9.
REQ-033 tempo=20 recarregar_14 -> 20 unchanged; tempo=9 recarregar_14 -> 14, still CONTANDO.
REQ-034 In ESGOTADO with buzzer=1, trocar_posse -> posse=1, tempo=24, estado=00, buzzer=0 next cycle.
REQ-035 tick, recarregar_24 and pausar same cycle at tempo=5 in CONTANDO -> tempo=24, estado stays 01.
REQ-036 Assert reset asynchronously mid-count at tempo=7, posse=1 -> outputs reach REQ-029 values before next clock edge.
